alu_multibyte_seq: RTL and testbench

//  Sequencer that sits directly upstream of the 8-bit ALU and also consumes its outputs.

---
 rtl/alu_multibyte_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq: drives an external 8-bit ALU one byte per cycle, LSB first,
// to perform a single BYTES-wide ADD/ADC/SUB/SBC/AND/OR/XOR/pass operation.
// The carry/borrow of each byte is chained into the next. The sequencer also
// assembles the result word and computes a whole-word zero flag.
// Optional feature macro: ALU_SEQ_OVF_EN adds output ovf, the signed overflow
// of the whole operation. Without the macro the port and its logic are absent.
module alu_multibyte_seq #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  input  logic [2:0]           op,
  input  logic [8*BYTES-1:0]   opA,
  input  logic [8*BYTES-1:0]   opB,
  input  logic                 cin,
  output logic [7:0]           aluA,
  output logic [7:0]           aluB,
  output logic                 aluCarryIn,
  output logic [2:0]           aluOp,
  input  logic [7:0]           aluResult,
  input  logic                 aluCarryOut,
  output logic [8*BYTES-1:0]   res,
  output logic                 cout,
  output logic                 zeroOut,
  output logic                 busy,
  output logic                 done
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int WIDTH = 8 * BYTES;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;         // operand A, shifted right one byte per EXEC cycle
  logic [WIDTH-1:0]  r_b;         // operand B, shifted right one byte per EXEC cycle
  logic [WIDTH-1:0]  r_res;
  logic [2:0]        r_op;
  logic              r_cin;
  logic              r_carry;     // carry/borrow chained between bytes
  logic              r_zacc;      // running "all bytes so far were zero"
  logic              r_cout;
  logic              r_zero;
  logic              r_busy;
  logic              r_done;
  logic [IW-1:0]     r_byte_idx;
`ifdef ALU_SEQ_OVF_EN
  logic              r_ovf;
`endif

  logic              w_exec;
  logic              w_arith;
  logic              w_first;
  logic              w_last;
  logic              w_byte_zero;
  logic              w_carry_next;

  assign w_exec       = (r_state == S_EXEC);
  assign w_arith      = ~r_op[2];
  assign w_first      = (r_byte_idx == '0);
  assign w_last       = (r_byte_idx == IW'(BYTES - 1));
  assign w_byte_zero  = (aluResult == 8'h00);
  // Logic ops never propagate a carry, whatever the ALU reports.
  assign w_carry_next = w_arith & aluCarryOut;

  // ALU drive: current low byte of the shift registers while executing, else all zero.
  // Bytes above 0 of an arithmetic op switch to the carry-consuming opcode (ADD->ADC, SUB->SBC).
  always_comb begin
    aluA       = 8'h00;
    aluB       = 8'h00;
    aluOp      = 3'b000;
    aluCarryIn = 1'b0;
    if (w_exec) begin
      aluA       = r_a[7:0];
      aluB       = r_b[7:0];
      aluOp      = (w_first || r_op[2]) ? r_op : {r_op[2:1], 1'b1};
      aluCarryIn = w_arith & (w_first ? r_cin : r_carry);
    end
  end

  // Control FSM plus datapath registers: accept, per-byte execute, one-cycle done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_op       <= 3'b000;
      r_cin      <= 1'b0;
      r_carry    <= 1'b0;
      r_zacc     <= 1'b0;
      r_cout     <= 1'b0;
      r_zero     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= '0;
`ifdef ALU_SEQ_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a        <= opA;
            r_b        <= opB;
            r_op       <= op;
            r_cin      <= cin;
            r_res      <= '0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_zacc     <= 1'b1;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
            r_ovf      <= 1'b0;
`endif
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res[8*r_byte_idx +: 8] <= aluResult;
          r_carry    <= w_carry_next;
          r_zacc     <= r_zacc & w_byte_zero;
          r_a        <= {8'h00, r_a[WIDTH-1:8]};
          r_b        <= {8'h00, r_b[WIDTH-1:8]};
          r_byte_idx <= r_byte_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_carry_next;
            r_zero  <= r_zacc & w_byte_zero;
`ifdef ALU_SEQ_OVF_EN
            // Top byte MSBs: a7/b7 from the shift registers, r7 from the ALU.
            if (!w_arith)
              r_ovf <= 1'b0;
            else if (!r_op[1])
              r_ovf <= (r_a[7] == r_b[7]) && (aluResult[7] != r_a[7]);
            else
              r_ovf <= (r_a[7] != r_b[7]) && (aluResult[7] != r_a[7]);
`endif
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready   = (r_state == S_IDLE) && !rst;
  assign res     = r_res;
  assign cout    = r_cout;
  assign zeroOut = r_zero;
  assign busy    = r_busy;
  assign done    = r_done;
`ifdef ALU_SEQ_OVF_EN
  assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq (BYTES=4): behavioural 8-bit ALU, whole-word
// reference model, scoreboard queue filled by the driver and drained by a
// separate monitor that checks every EXEC byte and every done pulse.
module tb_alu_multibyte_seq;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic          cin = 1'b0;
  logic [7:0]    aluA, aluB;
  logic          aluCarryIn;
  logic [2:0]    aluOp;
  logic [7:0]    aluResult;
  logic          aluCarryOut;
  logic [W-1:0]  res;
  logic          cout, zeroOut, busy, done;
`ifdef ALU_SEQ_OVF_EN
  logic          ovf;
`endif

  alu_multibyte_seq #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .op(op),
    .opA(opA), .opB(opB), .cin(cin),
    .aluA(aluA), .aluB(aluB), .aluCarryIn(aluCarryIn), .aluOp(aluOp),
    .aluResult(aluResult), .aluCarryOut(aluCarryOut),
    .res(res), .cout(cout), .zeroOut(zeroOut), .busy(busy), .done(done)
`ifdef ALU_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit ALU; opcode 111 passes A through.
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (aluOp)
      3'b000: t = {1'b0, aluA} + {1'b0, aluB};
      3'b001: t = {1'b0, aluA} + {1'b0, aluB} + {8'h00, aluCarryIn};
      3'b010: t = {({1'b0, aluA} < {1'b0, aluB}), aluA - aluB};
      3'b011: t = {({1'b0, aluA} < ({1'b0, aluB} + {8'h00, aluCarryIn})),
                   aluA - aluB - {7'h00, aluCarryIn}};
      3'b100: t = {1'b0, aluA & aluB};
      3'b101: t = {1'b0, aluA | aluB};
      3'b110: t = {1'b0, aluA ^ aluB};
      default: t = {1'b0, aluA};
    endcase
    aluResult   = t[7:0];
    aluCarryOut = t[8];
  end

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Operation currently in flight (for per-byte checks).
  logic [2:0]   cur_op = 3'b000;
  logic [W-1:0] cur_a = '0, cur_b = '0;
  logic         cur_cin = 1'b0;
  int           cur_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-word reference: plain W-bit arithmetic on the full operands.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, b, input logic c);
    exp_t e;
    logic [W:0] wide;
    wide = '0;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    e.acc  = 0;
    case (o)
      3'd0, 3'd1: begin
        wide   = {1'b0, a} + {1'b0, b} + ((o == 3'd1) ? {{W{1'b0}}, c} : '0);
        e.res  = wide[W-1:0];
        e.cout = wide[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd2, 3'd3: begin
        wide   = (o == 3'd3) ? {{W{1'b0}}, c} : '0;
        e.res  = a - b - wide[W-1:0];
        e.cout = ({1'b0, a} < ({1'b0, b} + wide));
        e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd4:    e.res = a & b;
      3'd5:    e.res = a | b;
      3'd6:    e.res = a ^ b;
      default: e.res = a;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Carry/borrow expected into byte k>0: computed from the low 8k bits of the operands.
  function automatic logic carry_into(input logic [2:0] o, input logic [W-1:0] a, b,
                                      input logic c, input int k);
    logic [W:0] mask, al, bl, c0, s;
    mask = ({{W{1'b0}}, 1'b1} << (8 * k)) - 1'b1;
    al   = {1'b0, a} & mask;
    bl   = {1'b0, b} & mask;
    c0   = (o == 3'd1 || o == 3'd3) ? {{W{1'b0}}, c} : '0;
    if (o[2]) return 1'b0;
    if (!o[1]) begin
      s = al + bl + c0;
      return s[8 * k];
    end
    return (al < (bl + c0));
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0: t = '0;
      1: t = '1;
      default: t = {$urandom(), $urandom()};
    endcase
    return t[W-1:0];
  endfunction

  // Monitor: pops the scoreboard on done, checks ALU drive every cycle.
  initial begin
    logic prev_done;
    int k;
    logic [2:0] eop;
    logic [W-1:0] sa, sb;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          check("done_pulse_prev", {63'd0, prev_done}, 64'd0);
          if (q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("res", res, e.res);
            check("cout", {63'd0, cout}, {63'd0, e.cout});
            check("zeroOut", {63'd0, zeroOut}, {63'd0, e.zero});
            check("latency", cyc - e.acc, BYTES);
`ifdef ALU_SEQ_OVF_EN
            check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
            $display("[TB] op=%0d res=0x%08h cout=%0b zero=%0b", cur_op, res, cout, zeroOut);
          end
        end else if (busy) begin
          k   = cyc - cur_acc;
          sa  = cur_a >> (8 * k);
          sb  = cur_b >> (8 * k);
          eop = (k == 0 || cur_op[2]) ? cur_op : {cur_op[2:1], 1'b1};
          check("aluA", aluA, sa[7:0]);
          check("aluB", aluB, sb[7:0]);
          check("aluOp", aluOp, eop);
          if (k == 0)
            check("aluCarryIn_b0", aluCarryIn, cur_op[2] ? 1'b0 : cur_cin);
          else
            check("aluCarryIn", aluCarryIn, carry_into(cur_op, cur_a, cur_b, cur_cin, k));
        end else begin
          check("alu_idle", {aluA, aluB, aluOp, aluCarryIn}, 20'd0);
        end
      end
      prev_done = done;
    end
  end

  // Issue one operation; hold>0 keeps start high (with scrambled inputs) through EXEC.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, b, input logic c,
                       input int hold, input bit push);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    op = o; opA = a; opB = b; cin = c; start = 1'b1;
    cur_op = o; cur_a = a; cur_b = b; cur_cin = c; cur_acc = cyc + 1;
    if (push) begin
      e = model(o, a, b, c);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      op = 3'($urandom_range(0, 7)); opA = rand_word(); opB = rand_word(); cin = ~cin;
      @(negedge clk);
    end
    start = 1'b0;
    opA = rand_word(); opB = rand_word();
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", res, 0);
    check("rst_flags", {cout, zeroOut}, 2'b00);
    check("rst_alu", {aluA, aluB, aluOp, aluCarryIn}, 20'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", ready, 1'b1);

    issue(3'd0, 32'h000000FF, 32'h00000001, 1'b0, 0, 1'b1);
    issue(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 1'b1);
    issue(3'd2, 32'h00000000, 32'h00000001, 1'b0, 0, 1'b1);
    issue(3'd1, 32'h7FFFFFFF, 32'h00000000, 1'b1, 0, 1'b1);
    issue(3'd6, 32'hA5A5A5A5, 32'hFFFF0000, 1'b1, 0, 1'b1);
    issue(3'd3, 32'h12345678, 32'h12345678, 1'b1, BYTES, 1'b1);
    issue(3'd5, 32'h0F0F0000, 32'h00F000F0, 1'b0, BYTES, 1'b1);

    // Abort in EXEC byte 2: no done, outputs back to reset values.
    issue(3'd0, 32'h11223344, 32'h55667788, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_res", res, 0);
    check("abort_flags", {cout, zeroOut}, 2'b00);
    rst = 1'b0;
    #1 check("abort_ready", ready, 1'b1);

    for (int n = 0; n < 40; n++)
      issue(3'($urandom_range(0, 7)), rand_word(), rand_word(), 1'($urandom_range(0, 1)), 0, 1'b1);

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", q.size(), 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
